// File: rtl/cordic_vectoring_engine_if.sv
// Cartesian-in / polar-out stream bundle for the vectoring CORDIC engine.
// Both sides use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high, and a held valid keeps its data stable until then.
interface cordic_vectoring_engine_if #(
  parameter int DATA_WIDTH = 18
);
  logic signed [DATA_WIDTH-1:0] in_x;
  logic signed [DATA_WIDTH-1:0] in_y;
  logic                         i_valid_in;
  logic                         o_ready_in;
  logic        [DATA_WIDTH:0]   o_mag;
  logic        [DATA_WIDTH-1:0] o_angle;
  logic                         o_valid_out;
  logic                         i_ready_out;

  modport master (
    output in_x, in_y, i_valid_in, i_ready_out,
    input  o_ready_in, o_mag, o_angle, o_valid_out
  );

  modport slave (
    input  in_x, in_y, i_valid_in, i_ready_out,
    output o_ready_in, o_mag, o_angle, o_valid_out
  );
endinterface

// File: rtl/cordic_vectoring_engine.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (K*|v|, angle in [0, 2*pi)),
// one shared shift-add element reused for N_ITER micro-rotations.
module cordic_vectoring_engine #(
  parameter int DATA_WIDTH = 18,
  parameter int N_ITER     = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  cordic_vectoring_engine_if.slave  bus,
  output logic [2:0]                dbg_state_o
);
  localparam int W = DATA_WIDTH;
  localparam int E = DATA_WIDTH + 2;

  localparam logic signed [E-1:0] OFF_PI2  = E'(6434);
  localparam logic signed [E-1:0] OFF_PI   = E'(12868);
  localparam logic signed [E-1:0] OFF_3PI2 = E'(19302);
  localparam logic signed [E-1:0] TWO_PI   = E'(25736);
  localparam logic [4:0]          LAST     = 5'(N_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FOLD  = 3'd1,
    S_ITER  = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic signed [E-1:0] x_q, x_d, y_q, y_d, z_q, z_d, off_q, off_d;
  logic [4:0]          i_q, i_d;
  logic                zero_q, zero_d;
  logic [W:0]          mag_q, mag_d;
  logic [W-1:0]        angle_q, angle_d;
  logic                valid_q, valid_d;
  logic signed [E-1:0] x_sh, y_sh, a_sum;

  // atan(2^-i) in the same 12-fractional-bit radian format as the angle output.
  function automatic logic signed [E-1:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    return E'(3217);
      5'd1:    return E'(1899);
      5'd2:    return E'(1003);
      5'd3:    return E'(509);
      5'd4:    return E'(256);
      5'd5:    return E'(128);
      5'd6:    return E'(64);
      5'd7:    return E'(32);
      5'd8:    return E'(16);
      5'd9:    return E'(8);
      5'd10:   return E'(4);
      5'd11:   return E'(2);
      5'd12:   return E'(1);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    off_d   = off_q;
    i_d     = i_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    angle_d = angle_q;
    valid_d = valid_q;
    x_sh    = x_q >>> i_q;
    y_sh    = y_q >>> i_q;
    a_sum   = off_q + z_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_valid_in) begin
          x_d     = {{2{bus.in_x[W-1]}}, bus.in_x};
          y_d     = {{2{bus.in_y[W-1]}}, bus.in_y};
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        // Two guard bits make negating the most negative input safe.
        zero_d = (x_q == '0) && (y_q == '0);
        z_d    = '0;
        i_d    = '0;
        case ({x_q[E-1], y_q[E-1]})
          2'b10: begin x_d = y_q;  y_d = -x_q; off_d = OFF_PI2;  end
          2'b11: begin x_d = -x_q; y_d = -y_q; off_d = OFF_PI;   end
          2'b01: begin x_d = -y_q; y_d = x_q;  off_d = OFF_3PI2; end
          default: off_d = '0;
        endcase
        state_d = S_ITER;
      end
      S_ITER: begin
        if (!y_q[E-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut(i_q);
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut(i_q);
        end
        i_d = i_q + 5'd1;
        if (i_q == LAST) state_d = S_FINAL;
      end
      S_FINAL: begin
        // Residual rotation error can push the sum just past either end of [0, 2*pi).
        if (zero_q || a_sum[E-1])  angle_d = '0;
        else if (a_sum >= TWO_PI)  angle_d = a_sum[W-1:0] - TWO_PI[W-1:0];
        else                       angle_d = a_sum[W-1:0];
        mag_d   = zero_q ? '0 : x_q[W:0];
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.i_ready_out) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      off_q   <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      off_q   <= off_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready_in  = (state_q == S_IDLE);
  assign bus.o_valid_out = valid_q;
  assign bus.o_mag       = mag_q;
  assign bus.o_angle     = angle_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_cordic_vectoring_engine.sv
// Bench for cordic_vectoring_engine: vector table, random vectors against a
// floating-point polar model, handshake/backpressure, latency and async reset.
module tb_cordic_vectoring_engine;
  localparam int    W      = 18;
  localparam int    N      = 15;
  localparam int    TWO_PI = 25736;
  localparam real   PI_R   = 3.14159265358979;
  localparam real   K_R    = 1.6467602581;

  typedef struct {
    int x;
    int y;
    int ang_lo;
    int ang_hi;
    int mag_lo;
    int mag_hi;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_vectoring_engine_if #(.DATA_WIDTH(W)) bus ();

  cordic_vectoring_engine #(.DATA_WIDTH(W), .N_ITER(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk_eq(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic chk_rng(input string name, input longint got, input longint lo, input longint hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic vec_t mk(input int x, input int y, input int alo, input int ahi,
                              input int mlo, input int mhi);
    vec_t v;
    v.x = x; v.y = y; v.ang_lo = alo; v.ang_hi = ahi; v.mag_lo = mlo; v.mag_hi = mhi;
    return v;
  endfunction

  // Reference from exact polar conversion, not from the CORDIC recurrence.
  function automatic vec_t model(input int x, input int y);
    real a, m;
    int  ea, em;
    a = $atan2(real'(y), real'(x));
    if (a < 0.0) a = a + 2.0 * PI_R;
    ea = $rtoi(a * 4096.0 + 0.5);
    m  = K_R * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    em = $rtoi(m + 0.5);
    return mk(x, y, ea - 5, ea + 5, em - em / 1000 - 4, em + em / 1000 + 4);
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.o_valid_out && bus.i_ready_out) begin
      chk_rng("output_expected", exp_q.size(), 1, 1 << 20);
      if (exp_q.size() > 0) begin
        vec_t e;
        int   ang;
        e   = exp_q.pop_front();
        ang = int'(bus.o_angle);
        chk_rng("angle_legal", ang, 0, TWO_PI - 1);
        if (ang + TWO_PI <= e.ang_hi)      ang = ang + TWO_PI;
        else if (ang - TWO_PI >= e.ang_lo) ang = ang - TWO_PI;
        chk_rng($sformatf("angle(%0d,%0d)", e.x, e.y), ang, e.ang_lo, e.ang_hi);
        chk_rng($sformatf("mag(%0d,%0d)", e.x, e.y), int'(bus.o_mag), e.mag_lo, e.mag_hi);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input vec_t v, input bit push, output int acc);
    int n = 0;
    @(negedge clk);
    while (!bus.o_ready_in && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk_rng("ready_in_wait", n, 0, 299);
    bus.in_x       = v.x[W-1:0];
    bus.in_y       = v.y[W-1:0];
    bus.i_valid_in = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) exp_q.push_back(v);
    @(negedge clk);
    bus.i_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.o_valid_out) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_rng("drain_wait", n, 0, 499);
  endtask

  // ---------------- test sequence ----------------
  vec_t tv[9];
  int   a1, a2, acc, n, x, y;
  logic [W:0]   snap_mag;
  logic [W-1:0] snap_ang;

  initial begin
    tv[0] = mk( 4096,      0,     0,     4,   6738,   6752);
    tv[1] = mk(    0,   4096,  6430,  6438,   6738,   6752);
    tv[2] = mk(-4096,      0, 12864, 12872,   6738,   6752);
    tv[3] = mk(    0,  -4096, 19298, 19306,   6738,   6752);
    tv[4] = mk(-4096,  -4096, 16081, 16089,   9529,   9549);
    tv[5] = mk(-131072, -131072, 16081, 16089, 304945, 305555);
    tv[6] = mk( 4096,     -1, 25728, 25735,   6738,   6752);
    tv[7] = mk( 4096,      1,     0,     4,   6738,   6752);
    tv[8] = mk(    0,      0,     0,     0,      0,      0);

    bus.in_x        = '0;
    bus.in_y        = '0;
    bus.i_valid_in  = 1'b0;
    bus.i_ready_out = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("reset_ready_in", bus.o_ready_in, 1);
    chk_eq("reset_valid_out", bus.o_valid_out, 0);
    chk_eq("reset_mag", bus.o_mag, 0);
    chk_eq("reset_angle", bus.o_angle, 0);
    chk_eq("reset_state", dbg_state, 0);
    rst_n = 1'b1;

    // Table vectors, then random vectors against the polar model.
    for (int i = 0; i < 9; i++) send(tv[i], 1'b1, acc);
    for (int i = 0; i < 8; i++) begin
      x = 0; y = 0;
      while ((x < 8192 && x > -8192) && (y < 8192 && y > -8192)) begin
        x = int'($urandom_range(0, 2 * 131071)) - 131071;
        y = int'($urandom_range(0, 2 * 131071)) - 131071;
      end
      send(model(x, y), 1'b1, acc);
    end
    drain();

    // Latency: zero vector, valid visible after edge N+2.
    send(tv[8], 1'b1, acc);
    n = 0;
    while (!bus.o_valid_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("latency", cyc - acc, N + 2);
    drain();

    // Back-to-back with downstream always ready.
    send(tv[4], 1'b1, a1);
    send(tv[1], 1'b1, a2);
    chk_eq("initiation_interval", a2 - a1, N + 4);
    drain();

    // Backpressure: results held, a stray valid is ignored.
    @(posedge clk);
    #1 bus.i_ready_out = 1'b0;
    send(tv[2], 1'b1, acc);
    n = 0;
    while (!bus.o_valid_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("bp_valid_seen", bus.o_valid_out, 1);
    snap_mag = bus.o_mag;
    snap_ang = bus.o_angle;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) begin
        bus.in_x       = 18'sh01234;
        bus.in_y       = -18'sh00777;
        bus.i_valid_in = 1'b1;
      end else begin
        bus.i_valid_in = 1'b0;
      end
      chk_eq("bp_mag_stable", bus.o_mag, snap_mag);
      chk_eq("bp_angle_stable", bus.o_angle, snap_ang);
      chk_eq("bp_valid_held", bus.o_valid_out, 1);
      chk_eq("bp_ready_in_low", bus.o_ready_in, 0);
    end
    bus.i_valid_in = 1'b0;
    @(posedge clk);
    #1 bus.i_ready_out = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("bp_valid_dropped", bus.o_valid_out, 0);
    chk_eq("bp_ready_in_back", bus.o_ready_in, 1);
    chk_eq("bp_state_idle", dbg_state, 0);
    repeat (25) @(negedge clk);
    chk_eq("stray_not_processed", bus.o_valid_out, 0);
    chk_eq("stray_queue_empty", exp_q.size(), 0);

    // Async reset in the middle of ITER, between clock edges.
    send(tv[0], 1'b0, acc);
    repeat (5) @(posedge clk);
    #3;
    chk_eq("pre_reset_in_iter", dbg_state, 2);
    rst_n = 1'b0;
    #1;
    chk_eq("areset_valid_out", bus.o_valid_out, 0);
    chk_eq("areset_ready_in", bus.o_ready_in, 1);
    chk_eq("areset_mag", bus.o_mag, 0);
    chk_eq("areset_angle", bus.o_angle, 0);
    chk_eq("areset_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(tv[5], 1'b1, acc);
    drain();
    repeat (3) @(negedge clk);
    chk_eq("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end
endmodule

// File: doc/cordic_vectoring_engine.md
# cordic_vectoring_engine

Iterative vectoring-mode CORDIC that converts a Cartesian vector (x, y) into polar form: uncompensated magnitude and angle in [0, 2π). It is the inverse companion of the rotation-mode sin/cos engine and uses the same angle format, so its angle output can feed that engine's angle input directly. A single shift-add processing element is reused for N_ITER iterations under a small FSM, with valid/ready handshakes on both sides.

## Interface
- DATA_WIDTH, 18: width of in_x, in_y and o_angle; must be ≥ 16.
- N_ITER, 15: number of CORDIC micro-rotations; legal range 1..16.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- in_x  in  DATA_WIDTH  signed x, two's complement, 12 fractional bits.
- in_y  in  DATA_WIDTH  signed y, same format.
- i_valid_in  in  1  input vector valid.
- o_ready_in  out  1  block can accept a vector; high only in IDLE.
- o_mag  out  DATA_WIDTH+1  unsigned magnitude × K, where K ≈ 1.64676; no gain compensation.
- o_angle  out  DATA_WIDTH  angle in radians, 12 fractional bits, range [0, 0x6488).
- o_valid_out  out  1  result valid; held until it is accepted.
- i_ready_out  in  1  downstream accepts the result.

## Operation
- FSM states: IDLE → FOLD → ITER → FINAL → DONE → IDLE.
- IDLE: o_ready_in=1. When i_valid_in is high, in_x and in_y are registered, sign-extended to DATA_WIDTH+2 bits (xr, yr), and the FSM moves to FOLD.
- FOLD (1 cycle): maps the vector into the first quadrant and sets the angle offset; z=0; iteration counter i=0.
  - x≥0, y≥0: (x, y), offset 0.
  - x<0, y≥0: (y, −x), offset 0x1922 (π/2).
  - x<0, y<0: (−x, −y), offset 0x3244 (π).
  - x≥0, y<0: (−y, x), offset 0x4B66 (3π/2).
- FOLD width rule: negating −2^(DATA_WIDTH−1) must not overflow; this is guaranteed by the 2-bit extension.
- ITER (N_ITER cycles), one micro-rotation per cycle:
  - If y≥0: x←x+(y>>>i), y←y−(x>>>i), z←z+atan_i.
  - Else: x←x−(y>>>i), y←y+(x>>>i), z←z−atan_i.
  - Shifts are arithmetic. The counter increments each cycle; the FSM leaves ITER after i=N_ITER−1.
- atan table: internal constant ROM, atan(2^−i)·4096 rounded to nearest. Entries i=0..4 are 0x0C91, 0x076B, 0x03EB, 0x01FD, 0x0100.
- FINAL (1 cycle):
  - a = offset + z.
  - If a<0, then a←0.
  - If a≥0x6488 (2π), then a←a−0x6488.
  - o_angle←a; o_mag←x[DATA_WIDTH:0]; o_valid_out←1.
- Zero vector: if the registered x=y=0, FINAL forces o_angle=0 and o_mag=0.
- DONE: outputs are held stable while o_valid_out=1. When i_ready_out=1, o_valid_out drops on that edge and the FSM returns to IDLE.
- i_valid_in is ignored outside IDLE; there is no queueing.

## Timing
- Reset values: FSM=IDLE, o_ready_in=1, o_valid_out=0, o_mag=0, o_angle=0, all internal registers 0.
- Latency: the accept edge is cycle 0. FOLD occupies edge 1, ITER edges 2..N_ITER+1, FINAL edge N_ITER+2. o_valid_out is high after edge N_ITER+2, which is 17 cycles for the defaults.
- Minimum initiation interval is N_ITER+4 cycles (accept, FOLD, N_ITER, FINAL, DONE with i_ready_out already high).
- o_ready_in falls on the accept edge and rises again on the edge where the output handshake completes.
- Backpressure: with i_ready_out=0, the block stays in DONE indefinitely and outputs do not change.
- Reset asserted in any state immediately returns all registers to their reset values; a partially computed result is discarded and never presented.
- Precision: with N_ITER=15, |o_angle error| ≤ 4 LSB and o_mag is within 0.1% of K·√(x²+y²).

## Test plan
- Axes: (0x1000, 0) → angle 0, mag 6745±7. (0, 0x1000) → angle 0x1922±4, mag 6745±7. (−0x1000, 0) → 0x3244±4. (0, −0x1000) → 0x4B66±4.
- Diagonal and extreme: (−0x1000, −0x1000) → angle 0x3ED5±4, mag 9539±10. (−0x20000, −0x20000) → mag 305250±305, no overflow, angle 0x3ED5±4.
- Wrap boundary: (0x1000, −1) → o_angle in [0x6480, 0x6487], never ≥0x6488. (0x1000, +1) → angle ≤ 4.
- Zero vector: (0, 0) → o_angle=0, o_mag=0 after 17 cycles.
- Handshake: hold i_ready_out=0 for 10 cycles after o_valid_out → outputs stable, o_ready_in=0, and a pulse on i_valid_in is ignored. Raise i_ready_out → one transfer, IDLE on the next cycle. Back-to-back vectors achieve an interval of 19 cycles.
- Async reset: assert i_rst_n=0 mid-ITER, between clock edges → o_valid_out=0 and o_ready_in=1 immediately. After release, a new vector produces a correct result with no residue from the aborted one.
